// File: rtl/pipeline_ctrl.sv
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Turns hazard-unit freeze/flush requests, the ihit/dhit memory
//                handshake and halt into per-stage latch enables and clears.
//                Optional macro PIPECTRL_PERF_EN adds saturating counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             freeze,
   input  logic             flush,
   input  logic             ihit,
   input  logic             dmem_req,
   input  logic             dhit,
   input  logic             halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             flush_pend,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;
   logic   r_pend,  w_pend_nxt;
   logic   w_dstall;
   logic   w_take_stall, w_take_bubble, w_take_flush;

   assign w_dstall   = dmem_req & ~dhit;
   assign flush_pend = r_pend;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= RUN;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pend_nxt    = r_pend;
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      ifid_flush    = 1'b0;
      idex_en       = 1'b0;
      idex_flush    = 1'b0;
      exmem_en      = 1'b0;
      memwb_en      = 1'b0;
      w_take_stall  = 1'b0;
      w_take_bubble = 1'b0;
      w_take_flush  = 1'b0;

      // Outputs are combinational, so reset must gate them explicitly.
      if (RST) begin
         w_state_nxt = RUN;
         w_pend_nxt  = 1'b0;
      end else if (r_state == HALTED) begin
         w_state_nxt = HALTED;
         w_pend_nxt  = 1'b0;
      end else if (halt) begin
         memwb_en    = 1'b1;
         w_state_nxt = HALTED;
         w_pend_nxt  = 1'b0;
      end else if (w_dstall) begin
         w_take_stall = 1'b1;
         w_state_nxt  = DWAIT;
         w_pend_nxt   = r_pend | flush;
      end else if (flush | r_pend) begin
         // A flush seen on the DWAIT exit cycle is consumed here along with pend.
         w_take_flush = 1'b1;
         w_state_nxt  = RUN;
         w_pend_nxt   = 1'b0;
         pc_en        = 1'b1;
         ifid_en      = 1'b1;
         ifid_flush   = 1'b1;
         idex_en      = 1'b1;
         idex_flush   = 1'b1;
         exmem_en     = 1'b1;
         memwb_en     = 1'b1;
      end else if (freeze) begin
         w_take_bubble = 1'b1;
         w_state_nxt   = RUN;
         idex_en       = 1'b1;
         idex_flush    = 1'b1;
         exmem_en      = 1'b1;
         memwb_en      = 1'b1;
      end else if (!ihit) begin
         w_take_bubble = 1'b1;
         w_state_nxt   = RUN;
         ifid_en       = 1'b1;
         ifid_flush    = 1'b1;
         idex_en       = 1'b1;
         exmem_en      = 1'b1;
         memwb_en      = 1'b1;
      end else begin
         w_state_nxt = RUN;
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
      end
   end

`ifdef PIPECTRL_PERF_EN
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_take_stall && r_stall_cnt != c_cnt_max)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_take_bubble && r_bubble_cnt != c_cnt_max)
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (w_take_flush && r_flush_cnt != c_cnt_max)
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
   assign flush_cnt  = r_flush_cnt;
`else
   logic w_unused;
   assign w_unused   = w_take_stall ^ w_take_bubble ^ w_take_flush;
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
   assign flush_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Directed self-checking bench for pipeline_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   localparam int CNT_W = 32;

   // Vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   localparam logic [6:0] c_zero   = 7'b0000000;
   localparam logic [6:0] c_all_en = 7'b1101011;
   localparam logic [6:0] c_flush  = 7'b1111111;
   localparam logic [6:0] c_freeze = 7'b0001111;
   localparam logic [6:0] c_noihit = 7'b0111011;
   localparam logic [6:0] c_halt   = 7'b0000001;

   logic CLK = 1'b0;
   logic RST, freeze, flush, ihit, dmem_req, dhit, halt;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, flush_pend;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
   logic [6:0] w_vec;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   assign w_vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .freeze     (freeze),
      .flush      (flush),
      .ihit       (ihit),
      .dmem_req   (dmem_req),
      .dhit       (dhit),
      .halt       (halt),
      .pc_en      (pc_en),
      .ifid_en    (ifid_en),
      .ifid_flush (ifid_flush),
      .idex_en    (idex_en),
      .idex_flush (idex_flush),
      .exmem_en   (exmem_en),
      .memwb_en   (memwb_en),
      .flush_pend (flush_pend),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt)
   );

   task automatic chk(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected counter value: real count with the perf macro, else tied to zero.
   function automatic logic [CNT_W-1:0] perf(input int v);
`ifdef PIPECTRL_PERF_EN
      return CNT_W'(v);
`else
      return CNT_W'(v * 0);
`endif
   endfunction

   // Advance to 1ns after the next rising edge, then apply inputs.
   task automatic step(input logic fz, input logic fl, input logic ih,
                       input logic dr, input logic dh, input logic hl);
      @(posedge CLK);
      #1;
      freeze = fz; flush = fl; ihit = ih; dmem_req = dr; dhit = dh; halt = hl;
      #2;
   endtask

   initial begin
      RST = 1'b1; freeze = 0; flush = 0; ihit = 1; dmem_req = 0; dhit = 0; halt = 0;
      repeat (2) @(posedge CLK);
      #3;
      chk("reset_vec",  {25'd0, w_vec}, {25'd0, c_zero});
      chk("reset_pend", {31'd0, flush_pend}, '0);
      chk("reset_scnt", stall_cnt, '0);

      // Release reset away from the edge; control is combinational.
      @(posedge CLK); #1; RST = 1'b0; #2;
      chk("post_reset", {25'd0, w_vec}, {25'd0, c_all_en});

      step(1, 0, 1, 0, 0, 0);
      chk("freeze", {25'd0, w_vec}, {25'd0, c_freeze});
      step(0, 0, 1, 0, 0, 0);
      chk("freeze_rel", {25'd0, w_vec}, {25'd0, c_all_en});
      chk("bubble_1", bubble_cnt, perf(1));

      // Three-cycle data stall with a flush pulsed on cycle 2.
      step(0, 0, 1, 1, 0, 0);
      chk("stall_c1", {25'd0, w_vec}, {25'd0, c_zero});
      step(0, 1, 1, 1, 0, 0);
      chk("stall_c2", {25'd0, w_vec}, {25'd0, c_zero});
      chk("pend_c2",  {31'd0, flush_pend}, '0);
      step(0, 0, 1, 1, 0, 0);
      chk("stall_c3", {25'd0, w_vec}, {25'd0, c_zero});
      chk("pend_c3",  {31'd0, flush_pend}, 1);
      step(0, 0, 1, 1, 1, 0);
      chk("dwait_exit", {25'd0, w_vec}, {25'd0, c_flush});
      step(0, 0, 1, 0, 0, 0);
      chk("no_double",  {25'd0, w_vec}, {25'd0, c_all_en});
      chk("pend_clear", {31'd0, flush_pend}, '0);
      chk("stall_3",    stall_cnt, perf(3));
      chk("flush_1",    flush_cnt, perf(1));

      // Flush wins over freeze.
      step(1, 1, 1, 0, 0, 0);
      chk("flush_freeze", {25'd0, w_vec}, {25'd0, c_flush});
      step(0, 0, 1, 0, 0, 0);
      chk("ff_after", {25'd0, w_vec}, {25'd0, c_all_en});
      chk("flush_2",  flush_cnt, perf(2));
      chk("bubble_1b", bubble_cnt, perf(1));

      // Two fetch-miss cycles.
      step(0, 0, 0, 0, 0, 0);
      chk("noihit_1", {25'd0, w_vec}, {25'd0, c_noihit});
      step(0, 0, 0, 0, 0, 0);
      chk("noihit_2", {25'd0, w_vec}, {25'd0, c_noihit});
      step(0, 0, 1, 0, 0, 0);
      chk("ihit_back", {25'd0, w_vec}, {25'd0, c_all_en});
      chk("bubble_3",  bubble_cnt, perf(3));

      // Flush during stall and again on the exit cycle: applied once.
      step(0, 1, 1, 1, 0, 0);
      chk("stall_fl", {25'd0, w_vec}, {25'd0, c_zero});
      step(0, 1, 1, 1, 1, 0);
      chk("exit_fl",  {25'd0, w_vec}, {25'd0, c_flush});
      chk("exit_pend", {31'd0, flush_pend}, 1);
      step(0, 0, 1, 0, 0, 0);
      chk("exit_after", {25'd0, w_vec}, {25'd0, c_all_en});
      chk("exit_pend0", {31'd0, flush_pend}, '0);

      // Consecutive flush cycles each apply.
      step(0, 1, 1, 0, 0, 0);
      chk("mflush_1", {25'd0, w_vec}, {25'd0, c_flush});
      step(0, 1, 1, 0, 0, 0);
      chk("mflush_2", {25'd0, w_vec}, {25'd0, c_flush});
      step(0, 0, 1, 0, 0, 0);
      chk("mflush_end", {25'd0, w_vec}, {25'd0, c_all_en});
      chk("flush_5",  flush_cnt, perf(5));
      chk("stall_4",  stall_cnt, perf(4));

      // Halt during a data stall, then terminal.
      step(0, 0, 1, 1, 0, 1);
      chk("halt_cyc", {25'd0, w_vec}, {25'd0, c_halt});
      step(1, 1, 1, 0, 0, 0);
      chk("halted_1", {25'd0, w_vec}, {25'd0, c_zero});
      chk("halted_pend", {31'd0, flush_pend}, '0);
      step(0, 0, 1, 0, 0, 0);
      chk("halted_2", {25'd0, w_vec}, {25'd0, c_zero});
      chk("halt_stall", stall_cnt, perf(4));
      chk("halt_flush", flush_cnt, perf(5));

      // Asynchronous reset mid-HALTED.
      #2; RST = 1'b1; #1;
      chk("rst_halted", {25'd0, w_vec}, {25'd0, c_zero});
      chk("rst_bcnt",   bubble_cnt, '0);
      @(posedge CLK); #1; RST = 1'b0; #2;
      chk("rst_resume", {25'd0, w_vec}, {25'd0, c_all_en});
      step(0, 0, 1, 0, 0, 0);
      chk("rst_run", {25'd0, w_vec}, {25'd0, c_all_en});
      chk("rst_fcnt", flush_cnt, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumer of the hazard unit's freeze/flush requests.
- Combines those requests with the memory handshake (ihit/dhit) and halt, then drives the per-stage enable and clear strobes of the four pipeline latches and the PC.
- Holds state so no flush request is lost during a memory stall, and keeps halt sticky.
- Sits between the hazard unit and the datapath latches.

Parameters:
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- freeze  in  1  load-use stall request from hazard unit.
- flush  in  1  branch/jump redirect request from hazard unit.
- ihit  in  1  instruction fetch complete this cycle.
- dmem_req  in  1  MEM-stage instruction has dREN or dWEN set.
- dhit  in  1  data access complete this cycle.
- halt  in  1  HALT has reached MEM/WB.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  IF/ID synchronous clear (bubble).
- idex_en  out  1  ID/EX latch enable.
- idex_flush  out  1  ID/EX synchronous clear.
- exmem_en  out  1  EX/MEM latch enable.
- memwb_en  out  1  MEM/WB latch enable.
- flush_pend  out  1  a flush is captured and awaiting release.
- stall_cnt  out  CNT_W  memory-stall cycle count.
- bubble_cnt  out  CNT_W  freeze/fetch bubble count.
- flush_cnt  out  CNT_W  applied flush count.

Behaviour:
- Clocking and reset:
  - One clock (CLK); reset RST is asynchronous and active-high.
  - While RST=1: state=RUN, pend=0, all outputs 0, counters 0.
  - First cycle after reset release follows the rules below.
- States:
  - RUN: normal issue.
  - DWAIT: data access outstanding.
  - HALTED: terminal until RST.
- Stall condition: dstall = dmem_req & ~dhit.
- Control outputs are combinational from the current state, pend and inputs. State and pend are registered.
- Per-cycle priority, highest first:
  1. HALTED: all enables 0, all flushes 0.
  2. halt=1 (any state): this cycle memwb_en=1, all other enables 0, flushes 0. Next state HALTED.
  3. dstall: all enables 0, flushes 0. Next state DWAIT. If flush=1, set pend.
  4. Flush, when flush | pend: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1. Clear pend. freeze is ignored this cycle.
  5. freeze: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
  6. ~ihit: pc_en=0, ifid_en=1, ifid_flush=1; idex_en, exmem_en and memwb_en all 1.
  7. Otherwise: all enables 1, flushes 0.
- DWAIT exits to RUN in the first cycle dstall=0. That cycle is evaluated with the priority list above, so a pending flush is applied exactly then.
- A flush arriving on the exit cycle itself is applied directly; pend must not double-apply on the next cycle.
- flush_pend output mirrors the pend register.
- flush asserted over multiple consecutive non-stall cycles: each cycle applies the flush (idempotent).
- Without the optional feature, the counter outputs are tied to 0.

Optional Feature:
- Macro: PIPECTRL_PERF_EN.
- When defined:
  - stall_cnt increments each cycle the dstall branch is taken.
  - bubble_cnt increments each cycle the freeze or ~ihit branch is taken.
  - flush_cnt increments each cycle the flush branch is taken.
  - All three saturate at all-ones, are cleared by RST, and hold in HALTED.
- When undefined: no counter flops exist and the counter outputs are constant 0. Control behaviour is identical either way.

Test Plan:
- Reset, then all inputs 0 except ihit=1 → outputs 0 during RST; first cycle after release all enables=1, flushes=0.
- freeze=1, ihit=1 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle back to all enables 1. With PIPECTRL_PERF_EN, bubble_cnt=1.
- dmem_req=1, dhit=0 for 3 cycles with flush pulsed on cycle 2 → 3 cycles all enables 0, flush_pend=1 from cycle 3. On the cycle dhit=1, ifid_flush=idex_flush=1 and pc_en=1. flush_pend=0 afterwards; no second flush the next cycle. stall_cnt=3, flush_cnt=1.
- flush=1 and freeze=1 same cycle → flush branch taken (ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1); freeze has no effect.
- ihit=0 for 2 cycles → pc_en=0, ifid_flush=1 both cycles, downstream enables 1.
- halt=1 while dstall active → memwb_en=1 that cycle, then all outputs 0 permanently. Later freeze/flush have no effect. Assert RST mid-HALTED → state RUN, outputs resume normal.
